// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through FIFO.
// Framing errors and dropped bytes are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     RX,
    input  logic                     rden,
    output logic [7:0]               data_out,
    output logic                     empty,
    output logic                     full,
    output logic [FIFO_DEPTH_LOG2:0] fill_lvl,
    output logic                     frame_err,
    output logic                     overrun
);
    localparam int          PW        = FIFO_DEPTH_LOG2 + 1;
    localparam int          DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    logic          rx_meta_reg;
    logic          rx_s_reg;
    state_t        state_reg, state_next;
    logic [15:0]   baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          push_req;
    logic          ferr_next;
    logic          frame_err_reg;
    logic          overrun_reg;
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [7:0]    mem [DEPTH];
    logic          pop;
    logic          push_ok;

    always_ff @(posedge CLK) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg     <= IDLE;
            baud_reg      <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_reg      <= baud_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            frame_err_reg <= ferr_next;
            overrun_reg   <= push_req && !push_ok;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push_req   = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                // Confirm the start bit at its middle; a high line here was a glitch.
                if (baud_reg == HALF_LAST) begin
                    if (!rx_s_reg) begin
                        baud_next  = '0;
                        bit_next   = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            DATA: begin
                if (baud_reg == BIT_LAST) begin
                    baud_next           = '0;
                    shift_next[bit_reg] = rx_s_reg;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (baud_reg == BIT_LAST) begin
                    baud_next = '0;
                    if (rx_s_reg) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fill_lvl = wptr_reg - rptr_reg;
    assign empty    = (fill_lvl == '0);
    assign full     = (fill_lvl == PW'(DEPTH));
    assign pop      = rden && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wptr_reg[FIFO_DEPTH_LOG2-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + PW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + PW'(1);
            end
        end
    end

    assign data_out  = empty ? 8'h00 : mem[rptr_reg[FIFO_DEPTH_LOG2-1:0]];
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vectors, corner sequences and
// randomized traffic checked against a byte-queue model of the receiver.
module tb_uart_rx_fifo;
    localparam int CPB = 8;
    // Edge (counted from the first posedge after the start bit is driven) on which the stop bit is sampled.
    localparam int W   = CPB / 2 + 2 + 9 * CPB;

    logic       CLK = 1'b0;
    logic       rst;
    logic       RX;
    logic       rden;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [4:0] fill_lvl;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp_fill;
        logic [7:0] exp_head;
    } vec_t;
    vec_t vecs[3];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(4)) dut (
        .CLK(CLK),
        .rst(rst),
        .RX(RX),
        .rden(rden),
        .data_out(data_out),
        .empty(empty),
        .full(full),
        .fill_lvl(fill_lvl),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    // Every post-edge cycle with a pulse high is counted, so a stretched pulse shows up.
    always @(posedge CLK) begin
        #1;
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] b, input logic stop_ok, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return stop_ok;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_fifo(input string tag);
        check({tag, " fill_lvl"}, 32'(fill_lvl), 32'(q.size()));
        check({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, " full"}, 32'(full), 32'(q.size() == 16));
        if (q.size() > 0) check({tag, " data_out"}, 32'(data_out), 32'(q[0]));
        check({tag, " frame_err count"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, " overrun count"}, 32'(ovr_cnt), 32'(exp_ovr));
    endtask

    task automatic model_good(input logic [7:0] b);
        if (q.size() < 16) q.push_back(b);
        else exp_ovr++;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input logic pop_at_write, input logic chk_timing);
        for (int c = 0; c < 10 * CPB; c++) begin
            RX   = frame_bit(b, stop_ok, c / CPB);
            rden = pop_at_write && (c == W);
            @(negedge CLK);
            if (chk_timing && (c + 1 == W))
                check("pre-write fill_lvl", 32'(fill_lvl), 32'd0);
            if (chk_timing && (c + 1 == W + 1)) begin
                check("post-write fill_lvl", 32'(fill_lvl), 32'd1);
                check("post-write data_out", 32'(data_out), 32'(b));
            end
        end
        rden = 1'b0;
        $display("[TB] frame 0x%02h stop=%0b pop_at_write=%0b fill_lvl=%0d", b, stop_ok, pop_at_write, fill_lvl);
    endtask

    task automatic pop_one(input string tag);
        if (q.size() > 0) check({tag, " head before pop"}, 32'(data_out), 32'(q[0]));
        rden = 1'b1;
        @(negedge CLK);
        rden = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_fifo({tag, " after pop"});
        $display("[TB] pop fill_lvl=%0d", fill_lvl);
    endtask

    initial begin
        logic [7:0] b;
        int op;

        vecs[0] = '{8'h00, 5'd1, 8'h00};
        vecs[1] = '{8'hFF, 5'd2, 8'h00};
        vecs[2] = '{8'h3C, 5'd3, 8'h00};

        rst = 1'b1; RX = 1'b1; rden = 1'b0;
        repeat (2) @(negedge CLK);
        check_fifo("reset");
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge CLK);

        // Single byte with exact write latency
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        model_good(8'hA5);
        check_fifo("single");
        pop_one("single");
        pop_one("empty rden");

        // Back-to-back table vectors
        for (int i = 0; i < 3; i++) begin
            send_frame(vecs[i].data, 1'b1, 1'b0, 1'b0);
            model_good(vecs[i].data);
            check("b2b fill_lvl", 32'(fill_lvl), 32'(vecs[i].exp_fill));
            check("b2b head", 32'(data_out), 32'(vecs[i].exp_head));
            check("b2b empty", 32'(empty), 32'd0);
        end
        check("b2b frame_err count", 32'(ferr_cnt), 32'd0);
        check("b2b overrun count", 32'(ovr_cnt), 32'd0);
        for (int i = 0; i < 3; i++) pop_one("b2b drain");

        // Glitch shorter than half a bit
        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        check_fifo("glitch");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        model_good(8'h5A);
        check_fifo("after glitch");
        pop_one("after glitch");

        // Framing error with line held low
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        repeat (CPB) @(negedge CLK);
        exp_ferr++;
        check_fifo("framing low");
        RX = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        check_fifo("framing recovered");
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        model_good(8'h42);
        check_fifo("after framing");
        pop_one("after framing");

        // Overrun on the 17th byte
        for (int v = 1; v <= 17; v++) begin
            send_frame(8'(v), 1'b1, 1'b0, 1'b0);
            model_good(8'(v));
            check_fifo("overrun fill");
        end
        for (int i = 0; i < 16; i++) pop_one("overrun drain");

        // Push while full is accepted when a pop coincides
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0);
            model_good(b);
        end
        check_fifo("refill");
        send_frame(8'h99, 1'b1, 1'b1, 1'b0);
        void'(q.pop_front());
        q.push_back(8'h99);
        check_fifo("push+pop while full");
        for (int i = 0; i < 16; i++) pop_one("full drain");

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        model_good(8'h11);
        for (int c = 0; c < 5 * CPB; c++) begin
            RX = frame_bit(8'hC3, 1'b1, c / CPB);
            @(negedge CLK);
        end
        RX = 1'b1;
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        q.delete();
        check_fifo("midframe reset");
        check("midframe reset data_out", 32'(data_out), 32'h00);
        check("midframe reset frame_err", 32'(frame_err), 32'd0);
        check("midframe reset overrun", 32'(overrun), 32'd0);
        repeat (2 * CPB) @(negedge CLK);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        model_good(8'h7E);
        check_fifo("after reset");

        // Randomized traffic against the queue model
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            b  = 8'($urandom);
            if (op <= 5) begin
                send_frame(b, 1'b1, 1'b0, 1'b0);
                model_good(b);
                check_fifo("rand good");
            end else if (op == 6) begin
                send_frame(b, 1'b0, 1'b0, 1'b0);
                RX = 1'b1;
                repeat (2 * CPB) @(negedge CLK);
                exp_ferr++;
                check_fifo("rand framing");
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) pop_one("rand pop");
            end
            repeat ($urandom_range(0, 20)) @(negedge CLK);
        end
        while (q.size() > 0) pop_one("final drain");
        pop_one("final empty rden");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
